// File: rtl/spi_pixel_strip_driver.sv
// SPI mode-0 frame receiver feeding a WS2812-style single-wire serialiser.
// Define PIXEL_DOUBLE_BUFFER_EN to build with a second (back) frame buffer.
module spi_pixel_strip_driver #(
  parameter int unsigned N_PIXELS = 8,
  parameter int unsigned BPP      = 24,
  parameter int unsigned T0H      = 35,
  parameter int unsigned T1H      = 70,
  parameter int unsigned TBIT     = 125,
  parameter int unsigned TRESET   = 5000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sclk,
  input  logic           mosi,
  input  logic           cs,
  output logic           dout,
  output logic           flushing,
  output logic           frame_err,
  output logic [BPP-1:0] last_pixel
);

  localparam int unsigned RW   = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
  localparam int unsigned WW   = $clog2(N_PIXELS + 1);
  localparam int unsigned BW   = $clog2(BPP);
  localparam int unsigned CMAX = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_LATCH} state_t;

  // Synchronisers; the extra stage on sclk/cs holds the previous value for edge detection
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[1:0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;
  logic cs_low;
  logic mosi_s;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_low    = ~cs_sync[1];
  assign mosi_s    = mosi_sync[1];

  logic [BPP-2:0] shift_q;
  logic [BW-1:0]  bit_cnt;
  logic [WW-1:0]  wr_idx;
  logic           overlong;
  logic           commit_q;
  logic           reject_q;
  logic [BPP-1:0] word_c;
  logic           word_done;
  logic           wr_ok;
  logic           wr_en;
  logic           frame_ok;
  logic [RW-1:0]  wr_addr;
  logic [BPP-1:0] rd_data;

  assign word_c    = {shift_q, mosi_s};
  assign word_done = cs_low & sclk_rise & (bit_cnt == BW'(BPP - 1));
  assign wr_ok     = (wr_idx < WW'(N_PIXELS));
  assign wr_addr   = RW'(wr_idx);

`ifdef PIXEL_DOUBLE_BUFFER_EN
  assign wr_en    = word_done & wr_ok;
  assign frame_ok = (wr_idx == WW'(N_PIXELS)) & (bit_cnt == '0) & ~overlong;
`else
  // Words arriving mid-flush are dropped so the transmitted frame stays intact
  logic blocked;
  assign wr_en    = word_done & wr_ok & ~flushing;
  assign frame_ok = (wr_idx == WW'(N_PIXELS)) & (bit_cnt == '0) & ~overlong
                    & ~blocked & ~flushing;
`endif

  // Receive path: shift, word assembly, frame validation
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      wr_idx     <= '0;
      overlong   <= 1'b0;
      last_pixel <= '0;
      commit_q   <= 1'b0;
      reject_q   <= 1'b0;
      frame_err  <= 1'b0;
`ifndef PIXEL_DOUBLE_BUFFER_EN
      blocked    <= 1'b0;
`endif
    end else begin
      commit_q  <= cs_rise & frame_ok;
      reject_q  <= cs_rise & ~frame_ok;
      frame_err <= reject_q;
      if (cs_fall) begin
        bit_cnt  <= '0;
        wr_idx   <= '0;
        overlong <= 1'b0;
`ifndef PIXEL_DOUBLE_BUFFER_EN
        blocked  <= 1'b0;
`endif
      end else if (cs_low && sclk_rise) begin
        shift_q <= word_c[BPP-2:0];
        if (word_done) begin
          bit_cnt    <= '0;
          last_pixel <= word_c;
          if (!wr_ok) begin
            overlong <= 1'b1;
          end else begin
            wr_idx <= wr_idx + WW'(1);
`ifndef PIXEL_DOUBLE_BUFFER_EN
            if (!wr_en) blocked <= 1'b1;
`endif
          end
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  logic [BPP-1:0] buf_a [N_PIXELS];
  logic [RW-1:0]  rd_idx;

`ifdef PIXEL_DOUBLE_BUFFER_EN
  // front selects the buffer being transmitted; SPI always fills the other one
  logic [BPP-1:0] buf_b [N_PIXELS];
  logic           front;
  logic           front_n;
  logic           pending;
  logic           pending_n;

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      if (front) buf_a[wr_addr] <= word_c;
      else       buf_b[wr_addr] <= word_c;
    end
  end

  assign rd_data = front ? buf_b[rd_idx] : buf_a[rd_idx];
`else
  always_ff @(posedge clk) begin
    if (reset && wr_en) buf_a[wr_addr] <= word_c;
  end

  assign rd_data = buf_a[rd_idx];
`endif

  state_t         state;
  state_t         state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic [BW-1:0]  bit_idx;
  logic [BW-1:0]  bit_idx_n;
  logic [RW-1:0]  rd_idx_n;
  logic [BPP-1:0] tx_word;
  logic [BPP-1:0] tx_word_n;
  logic           last_bit;
  logic           need_load;
  logic           bit_end;
  logic           latch_end;
  logic [CW-1:0]  leave_cnt;
  logic [CW-1:0]  high_end;

  // TX next-state; a mid-frame LOAD takes the last cycle of the outgoing bit
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    rd_idx_n  = rd_idx;
    tx_word_n = tx_word;
`ifdef PIXEL_DOUBLE_BUFFER_EN
    front_n   = front;
    pending_n = pending;
    if (commit_q && state != S_IDLE) pending_n = 1'b1;
`endif
    last_bit  = (bit_idx == '0);
    need_load = last_bit & (rd_idx != RW'(N_PIXELS - 1));
    leave_cnt = need_load ? CW'(TBIT - 2) : CW'(TBIT - 1);
    high_end  = tx_word[BPP-1] ? CW'(T1H - 1) : CW'(T0H - 1);
    bit_end   = (cnt == leave_cnt);
    latch_end = (cnt == CW'(TRESET - 1));

    case (state)
      S_IDLE: begin
        if (commit_q) begin
          state_n  = S_LOAD;
          rd_idx_n = '0;
`ifdef PIXEL_DOUBLE_BUFFER_EN
          front_n  = ~front;
`endif
        end
      end
      S_LOAD: begin
        tx_word_n = rd_data;
        bit_idx_n = BW'(BPP - 1);
        cnt_n     = '0;
        state_n   = S_HIGH;
      end
      S_HIGH, S_LOW: begin
        cnt_n = cnt + CW'(1);
        if (bit_end) begin
          if (need_load) begin
            state_n  = S_LOAD;
            rd_idx_n = rd_idx + RW'(1);
          end else if (last_bit) begin
            state_n = S_LATCH;
            cnt_n   = '0;
          end else begin
            state_n   = S_HIGH;
            cnt_n     = '0;
            bit_idx_n = bit_idx - BW'(1);
            tx_word_n = {tx_word[BPP-2:0], 1'b0};
          end
        end else if (state == S_HIGH && cnt == high_end) begin
          state_n = S_LOW;
        end
      end
      S_LATCH: begin
        cnt_n = cnt + CW'(1);
        if (latch_end) begin
`ifdef PIXEL_DOUBLE_BUFFER_EN
          if (pending || commit_q) begin
            state_n   = S_LOAD;
            rd_idx_n  = '0;
            front_n   = ~front;
            pending_n = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
`else
          state_n = S_IDLE;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rd_idx   <= '0;
      tx_word  <= '0;
      dout     <= 1'b0;
      flushing <= 1'b0;
`ifdef PIXEL_DOUBLE_BUFFER_EN
      front    <= 1'b0;
      pending  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      rd_idx   <= rd_idx_n;
      tx_word  <= tx_word_n;
      dout     <= (state_n == S_HIGH);
      flushing <= (state_n != S_IDLE);
`ifdef PIXEL_DOUBLE_BUFFER_EN
      front    <= front_n;
      pending  <= pending_n;
`endif
    end
  end

endmodule

// File: tb/tb_spi_pixel_strip_driver.sv
// Directed bench: a 3x24-bit strip (dut_a) and a 1x32-bit strip (dut_b) sharing sclk/mosi.
`timescale 1ns/1ps
module tb_spi_pixel_strip_driver;

  localparam int TB_T0H    = 35;
  localparam int TB_T1H    = 70;
  localparam int TB_TBIT   = 125;
  localparam int TB_TRESET = 5000;
`ifdef PIXEL_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_a = 1'b1;
  logic        cs_b = 1'b1;
  logic        dout_a, flushing_a, frame_err_a;
  logic [23:0] last_pixel_a;
  logic        dout_b, flushing_b, frame_err_b;
  logic [31:0] last_pixel_b;

  int checks = 0;
  int errors = 0;
  int err_cnt_a = 0;
  int hi_cnt_a = 0;

  logic sel = 1'b0;
  logic mon_dout, mon_flush, mon_err;
  assign mon_dout  = sel ? dout_b : dout_a;
  assign mon_flush = sel ? flushing_b : flushing_a;
  assign mon_err   = sel ? frame_err_b : frame_err_a;

  spi_pixel_strip_driver #(.N_PIXELS(3), .BPP(24), .T0H(35), .T1H(70), .TBIT(125), .TRESET(5000))
  dut_a (.clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs_a),
         .dout(dout_a), .flushing(flushing_a), .frame_err(frame_err_a), .last_pixel(last_pixel_a));

  spi_pixel_strip_driver #(.N_PIXELS(1), .BPP(32), .T0H(35), .T1H(70), .TBIT(125), .TRESET(5000))
  dut_b (.clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs_b),
         .dout(dout_b), .flushing(flushing_b), .frame_err(frame_err_b), .last_pixel(last_pixel_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err_a) err_cnt_a <= err_cnt_a + 1;
    if (dout_a) hi_cnt_a <= hi_cnt_a + 1;
  end

  task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (5) @(negedge clk);
    sclk = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Sends v[nbits-1:0] MSB first, then releases cs (raw rise happens at a negedge)
  task automatic spi_frame(input logic [127:0] v, input int nbits, input logic to_b);
    if (to_b) cs_b = 1'b0; else cs_a = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) spi_bit(v[i]);
    repeat (6) @(negedge clk);
    if (to_b) cs_b = 1'b1; else cs_a = 1'b1;
  endtask

  // Called right after the raw cs rise; returns on the first sample after posedge k+4
  task automatic check_commit(input string tag, input logic ok);
    repeat (3) @(negedge clk);
    check1({tag, " flushing at k+2"}, mon_flush, 1'b0);
    check1({tag, " frame_err at k+2"}, mon_err, 1'b0);
    @(negedge clk);
    check1({tag, " flushing at k+3"}, mon_flush, ok);
    check1({tag, " frame_err at k+3"}, mon_err, ~ok);
    check1({tag, " dout at k+3"}, mon_dout, 1'b0);
    @(negedge clk);
    check1({tag, " dout at k+4"}, mon_dout, ok);
    check1({tag, " frame_err at k+4"}, mon_err, 1'b0);
  endtask

  // Entered on the first high sample of the frame; measures every bit's high time and period
  task automatic tx_check(input string tag, input logic [127:0] v, input int nbits, input logic chained);
    int hi, lo, th;
    for (int i = nbits - 1; i >= 0; i--) begin
      th = v[i] ? TB_T1H : TB_T0H;
      hi = 0;
      while (mon_dout === 1'b1 && hi < 300) begin
        hi++;
        @(negedge clk);
      end
      checkv({tag, " bit high time"}, hi, th);
      lo = 0;
      if (i > 0) begin
        while (mon_dout !== 1'b1 && lo < 300) begin
          lo++;
          @(negedge clk);
        end
        checkv({tag, " bit period"}, hi + lo, TB_TBIT);
      end else begin
        while (mon_dout !== 1'b1 && mon_flush === 1'b1 && lo < 6000) begin
          lo++;
          @(negedge clk);
        end
        checkv({tag, " tail low + latch"}, lo, TB_TBIT - th + TB_TRESET + (chained ? 1 : 0));
        check1({tag, " flushing after latch"}, mon_flush, chained);
        check1({tag, " dout after latch"}, mon_dout, chained);
      end
    end
  endtask

  initial begin
    logic [127:0] fa, fs, fo, vb, fb, fc, fd, fe;
    int e0, h0;
    fa = {56'h0, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    fs = {56'h0, 24'h112233, 24'h445566, 24'h778899} >> 1;
    fo = {32'h0, 24'hAAAAAA, 24'h555555, 24'h0F0F0F, 24'hF0F0F0};
    vb = {96'h0, 32'h80000001};
    fb = {56'h0, 24'h800001, 24'hC3C3C3, 24'h00FF01};
    fc = {56'h0, 24'h5A5A5A, 24'h0F0F0F, 24'hF0F0F0};
    fd = {56'h0, 24'hFFC000, 24'h00FF00, 24'h0000FF};
    fe = {56'h0, 24'h123456, 24'h789ABC, 24'hDEF012};

    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check1("reset dout_a", dout_a, 1'b0);
    check1("reset flushing_a", flushing_a, 1'b0);
    check1("reset frame_err_a", frame_err_a, 1'b0);
    checkv("reset last_pixel_a", 32'(last_pixel_a), 32'h0);
    check1("reset dout_b", dout_b, 1'b0);
    checkv("reset last_pixel_b", last_pixel_b, 32'h0);

    // Valid 3-pixel frame
    sel = 1'b0;
    spi_frame(fa, 72, 1'b0);
    check_commit("frame A", 1'b1);
    tx_check("frame A", fa, 72, 1'b0);
    checkv("frame A last_pixel", 32'(last_pixel_a), 32'h0000FF);
    checkv("frame A no frame_err", err_cnt_a, 0);

    // 71 bits: incomplete word
    e0 = err_cnt_a;
    h0 = hi_cnt_a;
    spi_frame(fs, 71, 1'b0);
    check_commit("short frame", 1'b0);
    repeat (200) @(negedge clk);
    checkv("short frame err pulses", err_cnt_a - e0, 1);
    checkv("short frame no dout", hi_cnt_a - h0, 0);
    check1("short frame flushing", flushing_a, 1'b0);
    checkv("short frame last_pixel", 32'(last_pixel_a), 32'h445566);

    // 4 pixels into a 3-pixel strip
    e0 = err_cnt_a;
    h0 = hi_cnt_a;
    spi_frame(fo, 96, 1'b0);
    check_commit("overlong frame", 1'b0);
    repeat (200) @(negedge clk);
    checkv("overlong err pulses", err_cnt_a - e0, 1);
    checkv("overlong no dout", hi_cnt_a - h0, 0);
    check1("overlong flushing", flushing_a, 1'b0);
    checkv("overlong last_pixel", 32'(last_pixel_a), 32'hF0F0F0);

    // 32-bit single pixel on dut_b; dut_a must ignore the sclk traffic
    sel = 1'b1;
    e0 = err_cnt_a;
    h0 = hi_cnt_a;
    spi_frame(vb, 32, 1'b1);
    check_commit("32-bit frame", 1'b1);
    tx_check("32-bit frame", vb, 32, 1'b0);
    checkv("32-bit last_pixel", last_pixel_b, 32'h80000001);
    checkv("dut_a ignores sclk with cs high", 32'(last_pixel_a), 32'hF0F0F0);
    checkv("dut_a quiet during dut_b frame", (err_cnt_a - e0) + (hi_cnt_a - h0), 0);

    // Second valid frame arrives while the first is flushing
    sel = 1'b0;
    spi_frame(fb, 72, 1'b0);
    check_commit("frame B", 1'b1);
    e0 = err_cnt_a;
    fork
      tx_check("frame B", fb, 72, DB);
      begin
        spi_frame(fc, 72, 1'b0);
        repeat (10) @(negedge clk);
        checkv("frame C during flush err pulses", err_cnt_a - e0, DB ? 0 : 1);
        check1("frame C during flush flushing", flushing_a, 1'b1);
      end
    join
`ifdef PIXEL_DOUBLE_BUFFER_EN
    tx_check("frame C", fc, 72, 1'b0);
`endif
    h0 = hi_cnt_a;
    repeat (300) @(negedge clk);
    checkv("no extra frame after B/C", hi_cnt_a - h0, 0);
    check1("idle after B/C", flushing_a, 1'b0);

    // Reset in the middle of the 10th bit (a 1 bit, so dout is high)
    spi_frame(fd, 72, 1'b0);
    check_commit("frame D", 1'b1);
    repeat (9 * TB_TBIT + 60) @(negedge clk);
    check1("frame D dout high before reset", dout_a, 1'b1);
    check1("frame D flushing before reset", flushing_a, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check1("mid-frame reset dout", dout_a, 1'b0);
    check1("mid-frame reset flushing", flushing_a, 1'b0);
    checkv("mid-frame reset last_pixel", 32'(last_pixel_a), 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    spi_frame(fe, 72, 1'b0);
    check_commit("frame E", 1'b1);
    tx_check("frame E", fe, 72, 1'b0);
    checkv("frame E last_pixel", 32'(last_pixel_a), 32'hDEF012);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
